pipe_stage_reg: RTL

- Generic, parametrised inter-stage pipeline register for the 5-stage core (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque data payload plus a separate bank of write-enable bits.
- Adds to the fixed per-stage registers: a valid bit, flush priority, and a configurable stall-vector index.
- Instances replace hand-written stage registers; the write-enable bank covers regfile, HI/LO and LLbit enables.

---
 rtl/pipe_stage_reg.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register with valid bit, flush priority and stall-vector control.
// Defining PIPE_STAGE_PERF_CNT_EN adds saturating bubble_cnt / hold_cnt outputs.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W   = 102,
  parameter int unsigned       WE_W     = 3,
  parameter int unsigned       STALL_W  = 6,
  parameter int unsigned       STAGE    = 4,
  parameter logic [DATA_W-1:0] RST_DATA = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [WE_W-1:0]    in_we,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  output logic [WE_W-1:0]    out_we,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_held
`ifdef PIPE_STAGE_PERF_CNT_EN
  ,
  output logic [31:0]        bubble_cnt,
  output logic [31:0]        hold_cnt
`endif
);

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_HOLD   = 2'd2
  } act_e;

  logic              up_s;
  logic              dn_s;
  logic              unused_stall_s;
  act_e              act_s;

  logic              valid_q, valid_d;
  logic [WE_W-1:0]   we_q, we_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              held_q, held_d;

  // Only our own stage bit and the next one matter; the rest of the vector is deliberately ignored.
  assign up_s           = stall[STAGE];
  assign dn_s           = stall[STAGE+1];
  assign unused_stall_s = ^stall;

  // Select the edge action; flush beats every stall combination.
  always_comb begin
    act_s = ACT_HOLD;
    if (flush) begin
      act_s = ACT_BUBBLE;
    end else if (!up_s) begin
      act_s = ACT_LOAD;
    end else if (!dn_s) begin
      act_s = ACT_BUBBLE;
    end else begin
      act_s = ACT_HOLD;
    end
  end

  // Next-state contents; enables are gated by validity so out_valid=0 always implies out_we=0.
  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    data_d  = data_q;
    held_d  = 1'b0;
    case (act_s)
      ACT_LOAD: begin
        valid_d = in_valid;
        we_d    = in_we & {WE_W{in_valid}};
        data_d  = in_data;
        held_d  = 1'b0;
      end
      ACT_BUBBLE: begin
        valid_d = 1'b0;
        we_d    = {WE_W{1'b0}};
        data_d  = RST_DATA;
        held_d  = 1'b0;
      end
      ACT_HOLD: begin
        held_d  = 1'b1;
      end
      default: begin
        valid_d = 1'b0;
        we_d    = {WE_W{1'b0}};
        data_d  = RST_DATA;
        held_d  = 1'b0;
      end
    endcase
  end

  // Stage state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      we_q    <= {WE_W{1'b0}};
      data_q  <= RST_DATA;
      held_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      data_q  <= data_d;
      held_q  <= held_d;
    end
  end

  assign out_valid = valid_q;
  assign out_we    = we_q;
  assign out_data  = data_q;
  assign out_held  = held_q;

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;

  // Saturating event counters; they stick at all-ones instead of wrapping.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    if ((act_s == ACT_BUBBLE) && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end else begin
      bubble_cnt_d = bubble_cnt_q;
    end
    if ((act_s == ACT_HOLD) && (hold_cnt_q != 32'hFFFF_FFFF)) begin
      hold_cnt_d = hold_cnt_q + 32'd1;
    end else begin
      hold_cnt_d = hold_cnt_q;
    end
  end

  // Counter registers share the stage reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt_q <= 32'd0;
      hold_cnt_q   <= 32'd0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign hold_cnt   = hold_cnt_q;
`endif

endmodule
